// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared types, funct3 encodings and lane helpers for the LSU.
// Rev     : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only the five standard load/store encodings reach memory.
    function automatic logic f3_legal(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Drop the low address bits that a half or word access cannot use.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return addr_lo;
            2'b01:   return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Byte enables for a size (funct3[1:0]) at an already-aligned offset.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [31:0] shifted;
        shifted = word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    return word;
            F3_BU:   return {24'd0, shifted[7:0]};
            F3_HU:   return {16'd0, shifted[15:0]};
            default: return 32'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational lane steering: store replication / byte enables and
//           load byte/half extraction with sign or zero extension.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_stSize,
    input  logic [1:0]  i_stAddrLo,
    input  logic [31:0] i_stData,
    input  logic [2:0]  i_ldFunct3,
    input  logic [1:0]  i_ldAddrLo,
    input  logic [31:0] i_ldWord,
    output logic [1:0]  o_stAddrLo,
    output logic [3:0]  o_stBe,
    output logic [31:0] o_stData,
    output logic [31:0] o_ldData
);

    logic [1:0] w_alignedLo;

    assign w_alignedLo = align_lo(i_stSize, i_stAddrLo);
    assign o_stAddrLo  = w_alignedLo;
    assign o_stBe      = be_gen(i_stSize, w_alignedLo);

    // Replicate narrow store data across every lane so the byte enables alone pick the target.
    always_comb begin
        case (i_stSize)
            2'b00:   o_stData = {4{i_stData[7:0]}};
            2'b01:   o_stData = {2{i_stData[15:0]}};
            default: o_stData = i_stData;
        endcase
    end

    assign o_ldData = load_ext(i_ldWord, i_ldFunct3, i_ldAddrLo);

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module  : lsu_stage
// Purpose : Load/store unit between the M stage and data memory. Accepts one
//           request, holds the pipeline while memory is busy, returns the
//           extended load result in a one-cycle DONE slot.
// Config  : LSU_MISALIGN_TRAP_EN - misaligned H/W accesses raise excM and skip
//           memory instead of being forced to alignment.
// Rev     : 1.0  initial release
// ============================================================================
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       wdataM,
    output logic              stallM,
    output logic [31:0]       loaddataM,
    output logic              load_validM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              excM
);

    lsu_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addrLo;
    logic [MEM_AW-1:0] r_wordAddr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;

    logic              w_req;
    logic              w_busy;
    logic              w_misTrap;
    logic              w_skip;
    logic [1:0]        w_alignedLo;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ldData;
    logic              w_unusedAddrHi;

    assign w_unusedAddrHi = ^addrM[ADDR_W-1:MEM_AW+2];

    assign w_req  = memreadM | memwriteM;
    assign w_busy = (r_state == BUSY);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misTrap = ((funct3M[1:0] == 2'b01) && addrM[0]) ||
                       ((funct3M == F3_W) && (addrM[1:0] != 2'b00));
`else
    assign w_misTrap = 1'b0;
`endif

    // Requests that never touch memory go straight from IDLE to DONE.
    assign w_skip = !f3_legal(funct3M) || w_misTrap;

    lsu_align u_align (
        .i_stSize   (funct3M[1:0]),
        .i_stAddrLo (addrM[1:0]),
        .i_stData   (wdataM),
        .i_ldFunct3 (r_funct3),
        .i_ldAddrLo (r_addrLo),
        .i_ldWord   (mem_rdata),
        .o_stAddrLo (w_alignedLo),
        .o_stBe     (w_be),
        .o_stData   (w_wdata),
        .o_ldData   (w_ldData)
    );

    // Stall on the accept cycle (before state changes) and throughout BUSY.
    assign stallM = w_busy || ((r_state == IDLE) && w_req);

    // Memory side is quiet outside BUSY and held from the request registers inside it.
    assign mem_req   = w_busy;
    assign mem_we    = w_busy & r_we;
    assign mem_addr  = w_busy ? r_wordAddr : '0;
    assign mem_wdata = w_busy ? r_wdata : 32'd0;
    assign mem_be    = w_busy ? r_be : 4'd0;

    // Request FSM: latch on accept, wait for ready, present result for one DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addrLo    <= 2'd0;
            r_wordAddr  <= '0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            loaddataM   <= 32'd0;
            load_validM <= 1'b0;
            excM        <= 1'b0;
        end else begin
            load_validM <= 1'b0;
            excM        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_we       <= memwriteM;
                        r_funct3   <= funct3M;
                        r_addrLo   <= w_alignedLo;
                        r_wordAddr <= addrM[MEM_AW+1:2];
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        if (w_skip) begin
                            r_state   <= DONE;
                            excM      <= 1'b1;
                            loaddataM <= 32'd0;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_state <= DONE;
                        if (r_we) begin
                            loaddataM <= 32'd0;
                        end else begin
                            loaddataM   <= w_ldData;
                            load_validM <= 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_stage
// Purpose : Directed self-checking bench for lsu_stage.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM, memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] addrM, wdataM;
    logic        stallM, load_validM, mem_req, mem_we, mem_ready, excM;
    logic [31:0] loaddataM, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;

    int nChecks = 0;
    int nPass   = 0;

    // Per-operation observations gathered by run_op.
    int          obsStallCnt, obsDoneCyc, obsValidCyc;
    logic        obsReq, obsExc, obsWe;
    logic [7:0]  obsAddr;
    logic [3:0]  obsBe;
    logic [31:0] obsWdata, obsLoad, obsDoneData;

    lsu_stage #(.ADDR_W(32), .MEM_AW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreadM    (memreadM),
        .memwriteM   (memwriteM),
        .funct3M     (funct3M),
        .addrM       (addrM),
        .wdataM      (wdataM),
        .stallM      (stallM),
        .loaddataM   (loaddataM),
        .load_validM (load_validM),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .excM        (excM)
    );

    always #5 clk = ~clk;

    // Issue one request from IDLE and record what the DUT does until DONE.
    // Cycle 1 is the accept cycle; returns one clock after the DONE cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits);
        int busyCnt;
        logic done;
        busyCnt = 0; done = 1'b0;
        obsStallCnt = 0; obsDoneCyc = 0; obsValidCyc = 0;
        obsReq = 1'b0; obsExc = 1'b0; obsWe = 1'b0;
        obsAddr = 8'd0; obsBe = 4'd0; obsWdata = 32'd0; obsLoad = 32'd0; obsDoneData = 32'd0;
        memreadM = rd; memwriteM = wr; funct3M = f3; addrM = a; wdataM = wd; mem_rdata = rdat;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            mem_ready = mem_req && (busyCnt >= waits);
            #1;
            if (stallM) obsStallCnt++;
            if (excM) obsExc = 1'b1;
            if (load_validM) begin
                obsValidCyc = cyc;
                obsLoad = loaddataM;
            end
            if (mem_req) begin
                obsReq = 1'b1; obsWe = mem_we; obsAddr = mem_addr;
                obsBe = mem_be; obsWdata = mem_wdata;
                busyCnt++;
            end
            if (!stallM) begin
                obsDoneCyc = cyc;
                obsDoneData = loaddataM;
                done = 1'b1;
                memreadM = 1'b0; memwriteM = 1'b0; mem_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            nChecks++;
            $display("FAIL op_timeout: no DONE cycle within 40 cycles (f3=%b addr=%h)", f3, a);
            memreadM = 1'b0; memwriteM = 1'b0; mem_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; funct3M = 3'd0;
        addrM = 32'd0; wdataM = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        nChecks++;
        if ({stallM, load_validM, mem_req, mem_we, excM} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {stallM, load_validM, mem_req, mem_we, excM});
        else nPass++;
        nChecks++;
        if ({loaddataM, mem_wdata, mem_addr, mem_be} !== 76'd0)
            $display("FAIL reset_data: got ld=%h wd=%h a=%h be=%h want all 0", loaddataM, mem_wdata, mem_addr, mem_be);
        else nPass++;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0);
        nChecks++;
        if ({obsWe, obsAddr, obsBe, obsWdata} !== {1'b1, 8'h04, 4'b1111, 32'hDEAD_BEEF})
            $display("FAIL sw_bus: got we=%b a=%h be=%b wd=%h want 1 04 1111 deadbeef", obsWe, obsAddr, obsBe, obsWdata);
        else nPass++;
        nChecks++;
        if (obsStallCnt !== 2 || obsDoneCyc !== 3)
            $display("FAIL sw_timing: got stall=%0d done=%0d want 2 3", obsStallCnt, obsDoneCyc);
        else nPass++;
    endtask

    task automatic test_store_byte();
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'd0, 0);
        nChecks++;
        if ({obsAddr, obsBe, obsWdata} !== {8'h04, 4'b1000, 32'hA5A5_A5A5})
            $display("FAIL sb_bus: got a=%h be=%b wd=%h want 04 1000 a5a5a5a5", obsAddr, obsBe, obsWdata);
        else nPass++;
    endtask

    task automatic test_load_byte();
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0021, 32'd0, 32'h0000_8000, 3);
        nChecks++;
        if (obsLoad !== 32'hFFFF_FF80 || obsValidCyc !== 6)
            $display("FAIL lb_data: got ld=%h valid@%0d want ffffff80 @6", obsLoad, obsValidCyc);
        else nPass++;
        nChecks++;
        if (obsStallCnt !== 5 || obsWe !== 1'b0 || obsAddr !== 8'h08)
            $display("FAIL lb_bus: got stall=%0d we=%b a=%h want 5 0 08", obsStallCnt, obsWe, obsAddr);
        else nPass++;
    endtask

    task automatic test_load_half_u();
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'd0, 32'hBEEF_1234, 1);
        nChecks++;
        if (obsLoad !== 32'h0000_BEEF || obsValidCyc !== 4)
            $display("FAIL lhu_data: got ld=%h valid@%0d want 0000beef @4", obsLoad, obsValidCyc);
        else nPass++;
    endtask

    task automatic test_misaligned_word();
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'h1234_5678, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        nChecks++;
        if (obsExc !== 1'b1 || obsReq !== 1'b0 || obsDoneData !== 32'd0 || obsValidCyc !== 0)
            $display("FAIL lw_misalign: got exc=%b req=%b ld=%h valid@%0d want 1 0 0 none", obsExc, obsReq, obsDoneData, obsValidCyc);
        else nPass++;
`else
        nChecks++;
        if (obsAddr !== 8'h01 || obsBe !== 4'b1111 || obsLoad !== 32'h1234_5678 || obsExc !== 1'b0)
            $display("FAIL lw_misalign: got a=%h be=%b ld=%h exc=%b want 01 1111 12345678 0", obsAddr, obsBe, obsLoad, obsExc);
        else nPass++;
`endif
    endtask

    task automatic test_illegal_funct3();
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'd0, 32'hFFFF_FFFF, 0);
        nChecks++;
        if (obsReq !== 1'b0 || obsExc !== 1'b1 || obsDoneData !== 32'd0 || obsDoneCyc !== 2)
            $display("FAIL illegal_f3: got req=%b exc=%b ld=%h done@%0d want 0 1 0 @2", obsReq, obsExc, obsDoneData, obsDoneCyc);
        else nPass++;
    endtask

    task automatic test_both_set();
        run_op(1'b1, 1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        nChecks++;
        if ({obsWe, obsBe, obsWdata} !== {1'b1, 4'b1100, 32'h1234_1234})
            $display("FAIL both_bus: got we=%b be=%b wd=%h want 1 1100 12341234", obsWe, obsBe, obsWdata);
        else nPass++;
        nChecks++;
        if (obsValidCyc !== 0 || obsDoneData !== 32'd0)
            $display("FAIL both_load: got valid@%0d ld=%h want none 0", obsValidCyc, obsDoneData);
        else nPass++;
    endtask

    task automatic test_reset_busy();
        memreadM = 1'b1; memwriteM = 1'b0; funct3M = 3'b010; addrM = 32'h0000_0008;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nChecks++;
        if (mem_req !== 1'b1 || stallM !== 1'b1)
            $display("FAIL rb_busy: got req=%b stall=%b want 1 1", mem_req, stallM);
        else nPass++;
        reset = 1'b1; memreadM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        nChecks++;
        if ({mem_req, stallM, load_validM} !== 3'b000)
            $display("FAIL rb_abort: got req=%b stall=%b valid=%b want 0 0 0", mem_req, stallM, load_validM);
        else nPass++;
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_000C, 32'd0, 32'hCAFE_F00D, 1);
        nChecks++;
        if (obsLoad !== 32'hCAFE_F00D || obsValidCyc !== 4 || obsAddr !== 8'h03)
            $display("FAIL rb_after: got ld=%h valid@%0d a=%h want cafef00d @4 03", obsLoad, obsValidCyc, obsAddr);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_000E, 32'd0, 32'h8001_0000, 0);
        nChecks++;
        if (obsLoad !== 32'hFFFF_8001 || obsBe !== 4'b1100)
            $display("FAIL b2b_lh: got ld=%h be=%b want ffff8001 1100", obsLoad, obsBe);
        else nPass++;
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'd0, 32'hF000_0000, 2);
        nChecks++;
        if (obsLoad !== 32'h0000_00F0 || obsValidCyc !== 5)
            $display("FAIL b2b_lbu: got ld=%h valid@%0d want 000000f0 @5", obsLoad, obsValidCyc);
        else nPass++;
        nChecks++;
        if (loaddataM !== 32'h0000_00F0 || load_validM !== 1'b0)
            $display("FAIL b2b_hold: got ld=%h valid=%b want 000000f0 0", loaddataM, load_validM);
        else nPass++;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_load_half_u();
        test_misaligned_word();
        test_illegal_funct3();
        test_both_set();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
